// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: decode-stage PC sequencing control.
// Detects load-use and branch-operand hazards, tracks instruction-memory
// wait cycles with a sticky timeout, and resolves jump/branch/jr redirects
// with fixed priority. Branch delay slots are architectural, so there is
// no flush output.
module pc_redirect_ctrl #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic        dec_is_j,
    input  logic        dec_is_jr,
    input  logic        dec_is_beq,
    input  logic        dec_is_bne,
    input  logic        br_eq,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_uses_rt,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dst,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dst,
    input  logic        imem_ready,
    output logic        d_stall,
    output logic        jump,
    output logic        branch,
    output logic        jump_reg,
    output logic        ex_bubble,
    output logic [1:0]  ctrl_state,
    output logic        imem_timeout,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        IWAIT = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic        ctl;
    logic        hazard;
    logic        take_br;

    // A register-zero destination never creates a dependency.
    function automatic logic src_hit(input logic [4:0] r);
        return (r != 5'd0) && ((r == dec_rs) || (dec_uses_rt && (r == dec_rt)));
    endfunction

    // Hazard detection, stall and redirect resolution.
    always_comb begin
        ctl     = dec_is_beq | dec_is_bne | dec_is_jr;
        hazard  = dec_valid &
                  ((ex_reg_write & src_hit(ex_dst) & (ex_mem_read | ctl)) |
                   (mem_mem_read & src_hit(mem_dst) & ctl));
        take_br = (dec_is_beq & br_eq) | (dec_is_bne & ~br_eq);

        d_stall  = 1'b0;
        jump     = 1'b0;
        branch   = 1'b0;
        jump_reg = 1'b0;
        if (!rst) begin
            d_stall = (state_q == ERR) ? 1'b1 : (~imem_ready | hazard);
            if (!d_stall && dec_valid) begin
                jump     = dec_is_j;
                branch   = take_br & ~dec_is_j;
                jump_reg = dec_is_jr & ~dec_is_j & ~take_br;
            end
        end
        ex_bubble = d_stall;
    end

    // Next-state, wait counter, sticky timeout and stall counter.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q + {31'd0, d_stall};

        if (imem_ready) begin
            wait_cnt_d = '0;
        end else if (state_q != ERR) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        if (state_q != ERR) begin
            if (!imem_ready) begin
                if (wait_cnt_q == 8'(MAX_WAIT - 1)) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                end else begin
                    state_d = IWAIT;
                end
            end else if (hazard) begin
                state_d = HAZ;
            end else begin
                state_d = RUN;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ctrl_state   = state_q;
    assign imem_timeout = timeout_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural reference model.
module tb_pc_redirect_ctrl;

    localparam int unsigned MW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid, dec_is_j, dec_is_jr, dec_is_beq, dec_is_bne, br_eq;
    logic [4:0]  dec_rs, dec_rt;
    logic        dec_uses_rt;
    logic        ex_reg_write, ex_mem_read;
    logic [4:0]  ex_dst;
    logic        mem_mem_read;
    logic [4:0]  mem_dst;
    logic        imem_ready;
    logic        d_stall, jump, branch, jump_reg, ex_bubble;
    logic [1:0]  ctrl_state;
    logic        imem_timeout;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int          m_state;
    int          m_wait;
    bit          m_to;
    logic [31:0] m_stall;

    pc_redirect_ctrl #(.MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_is_j(dec_is_j), .dec_is_jr(dec_is_jr),
        .dec_is_beq(dec_is_beq), .dec_is_bne(dec_is_bne), .br_eq(br_eq),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_uses_rt(dec_uses_rt),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dst(ex_dst),
        .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .imem_ready(imem_ready),
        .d_stall(d_stall), .jump(jump), .branch(branch), .jump_reg(jump_reg),
        .ex_bubble(ex_bubble), .ctrl_state(ctrl_state),
        .imem_timeout(imem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 0; dec_valid = 0; dec_is_j = 0; dec_is_jr = 0; dec_is_beq = 0;
        dec_is_bne = 0; br_eq = 0; dec_rs = 0; dec_rt = 0; dec_uses_rt = 0;
        ex_reg_write = 0; ex_mem_read = 0; ex_dst = 0; mem_mem_read = 0;
        mem_dst = 0; imem_ready = 1;
    endtask

    function automatic bit reads(input logic [4:0] r);
        return r != 0 && (r == dec_rs || (dec_uses_rt && r == dec_rt));
    endfunction

    // Compare every output against the model, advance the model, wait a cycle.
    task automatic step();
        bit haz, stall, tb, is_ctl;
        bit e_j, e_b, e_jr;
        #1;
        is_ctl = dec_is_beq || dec_is_bne || dec_is_jr;
        haz = dec_valid && ((ex_reg_write && reads(ex_dst) && (ex_mem_read || is_ctl)) ||
                            (mem_mem_read && reads(mem_dst) && is_ctl));
        stall = !rst && (m_state == 3 || !imem_ready || haz);
        tb = (dec_is_beq && br_eq) || (dec_is_bne && !br_eq);
        e_j = 0; e_b = 0; e_jr = 0;
        if (!rst && !stall && dec_valid) begin
            if (dec_is_j) e_j = 1;
            else if (tb) e_b = 1;
            else if (dec_is_jr) e_jr = 1;
        end
        check("d_stall", d_stall, stall);
        check("ex_bubble", ex_bubble, stall);
        check("jump", jump, e_j);
        check("branch", branch, e_b);
        check("jump_reg", jump_reg, e_jr);
        check("ctrl_state", ctrl_state, m_state);
        check("imem_timeout", imem_timeout, m_to);
        check("stall_cycles", stall_cycles, m_stall);
        if (rst) begin
            m_state = 0; m_wait = 0; m_to = 0; m_stall = 0;
        end else begin
            m_stall = m_stall + (stall ? 32'd1 : 32'd0);
            if (imem_ready) begin
                m_wait = 0;
                if (m_state != 3) m_state = haz ? 1 : 0;
            end else if (m_state != 3) begin
                if (m_wait + 1 >= MW) begin
                    m_state = 3; m_to = 1;
                end else begin
                    m_state = 2;
                end
                m_wait++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); idle();
    endtask

    initial begin
        m_state = 0; m_wait = 0; m_to = 0; m_stall = 0;
        idle();
        rst = 1;
        @(negedge clk);
        #1 check("rst_d_stall", d_stall, 0);
        step(); step();
        idle();
        #1;
        check("rst_state", ctrl_state, 0);
        check("rst_timeout", imem_timeout, 0);
        check("rst_stall_cycles", stall_cycles, 0);

        // Load-use
        dec_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5; dec_rs = 5;
        #1 check("lu_stall", d_stall, 1);
        check("lu_bubble", ex_bubble, 1);
        step();
        check("lu_haz", ctrl_state, 1);
        ex_reg_write = 0;
        #1 check("lu_clear", d_stall, 0);
        step();
        check("lu_run", ctrl_state, 0);

        // Register zero
        ex_reg_write = 1; ex_dst = 0; dec_rs = 0;
        #1 check("r0_nostall", d_stall, 0);
        step();

        // Branch after ALU op, then after load in MEM
        idle(); dec_valid = 1; dec_is_beq = 1; dec_uses_rt = 1; dec_rt = 3;
        ex_reg_write = 1; ex_dst = 3;
        #1 check("br_alu_stall", d_stall, 1);
        check("br_alu_nobr", branch, 0);
        step();
        ex_reg_write = 0; mem_mem_read = 1; mem_dst = 3;
        #1 check("br_mem_stall", d_stall, 1);
        step();
        mem_mem_read = 0; br_eq = 1;
        #1 check("br_taken", branch, 1);
        check("br_taken_nostall", d_stall, 0);
        step();

        // Priority
        idle(); dec_valid = 1; dec_is_j = 1; dec_is_bne = 1; br_eq = 0;
        #1 check("pri_jump", jump, 1);
        check("pri_nobranch", branch, 0);
        step();
        imem_ready = 0;
        #1 check("pri_wait_jump", jump, 0);
        check("pri_wait_branch", branch, 0);
        step();

        // Counter: 3 hazard cycles then 2 wait cycles
        do_reset();
        dec_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_dst = 7; dec_rs = 7;
        repeat (3) step();
        idle(); imem_ready = 0;
        repeat (2) step();
        idle();
        #1 check("cnt_five", stall_cycles, 5);
        step();

        // Timeout
        do_reset();
        imem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1 check("to_stall", d_stall, 1);
            step();
        end
        check("to_err", ctrl_state, 3);
        check("to_flag", imem_timeout, 1);
        imem_ready = 1;
        #1 check("err_stall", d_stall, 1);
        step();
        check("err_hold", ctrl_state, 3);
        rst = 1;
        #1 check("err_rst_stall", d_stall, 0);
        step();
        idle();
        #1;
        check("err_rst_state", ctrl_state, 0);
        check("err_rst_flag", imem_timeout, 0);
        check("err_rst_cnt", stall_cycles, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(99) < 3);
            dec_valid    = ($urandom_range(9) < 8);
            dec_is_j     = ($urandom_range(9) < 2);
            dec_is_jr    = ($urandom_range(9) < 2);
            dec_is_beq   = ($urandom_range(9) < 3);
            dec_is_bne   = ($urandom_range(9) < 3);
            br_eq        = 1'($urandom);
            dec_rs       = 5'($urandom_range(3));
            dec_rt       = 5'($urandom_range(3));
            dec_uses_rt  = 1'($urandom);
            ex_reg_write = 1'($urandom);
            ex_mem_read  = 1'($urandom);
            ex_dst       = 5'($urandom_range(3));
            mem_mem_read = 1'($urandom);
            mem_dst      = 5'($urandom_range(3));
            imem_ready   = ($urandom_range(99) < 80);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
